// File: rtl/register_pc_stack.sv
// register_pc_stack: program-counter unit with a hardware return-address stack.
//   The W-bit PC can be loaded byte lane by byte lane from the ALU, incremented by STEP,
//   pushed on a call, or popped on a return. A DEPTH-entry circular buffer holds the
//   return addresses.
// Ports:
//   Clk, Rst        clock; synchronous active-high reset
//   notALUResult    inverted ALU result, used as the load target and the call target
//   PR_Write_PC     per-byte-lane load enables
//   PR_Inc_PC       PC <= PC + STEP
//   PR_Call/PR_Ret  push the return address and jump / pop into PC
//   PC, notPC       program counter and its complement, both registered
//   StackDepth/StackEmpty/StackFull   occupancy of the return stack
//   StackOverflow/StackUnderflow      sticky error flags, cleared only by Rst
module register_pc_stack #(
  parameter int unsigned W        = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned STEP     = 1,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [W-1:0]                 notALUResult,
  input  logic [W/8-1:0]               PR_Write_PC,
  input  logic                         PR_Inc_PC,
  input  logic                         PR_Call,
  input  logic                         PR_Ret,
  output logic [W-1:0]                 PC,
  output logic [W-1:0]                 notPC,
  output logic [$clog2(DEPTH+1)-1:0]   StackDepth,
  output logic                         StackEmpty,
  output logic                         StackFull,
  output logic                         StackOverflow,
  output logic                         StackUnderflow
);

  localparam int unsigned LANES = W / 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [W-1:0]  STEP_W   = W'(STEP);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [W-1:0]  r_pc;
  logic [W-1:0]  r_not_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_top;
  logic          r_ovf;
  logic          r_udf;
  logic [W-1:0]  r_stack [DEPTH];

  logic [W-1:0]  w_target;
  logic [W-1:0]  w_pc_inc;
  logic [W-1:0]  w_pc_next;
  logic [CW-1:0] w_count_next;
  logic [PW-1:0] w_top_next;
  logic [PW-1:0] w_top_inc;
  logic [PW-1:0] w_top_dec;
  logic          w_push;
  logic          w_ovf_next;
  logic          w_udf_next;

  assign w_target  = ~notALUResult;
  // Full-width add so the carry crosses lanes before lane selection.
  assign w_pc_inc  = r_pc + STEP_W;
  assign w_top_inc = (r_top == LAST_PTR) ? '0 : r_top + PW'(1);
  assign w_top_dec = (r_top == '0) ? LAST_PTR : r_top - PW'(1);

  always_comb begin
    w_pc_next    = r_pc;
    w_count_next = r_count;
    w_top_next   = r_top;
    w_push       = 1'b0;
    w_ovf_next   = r_ovf;
    w_udf_next   = r_udf;
    if (PR_Ret) begin
      if (r_count != '0) begin
        w_pc_next    = r_stack[r_top];
        w_count_next = r_count - CW'(1);
        w_top_next   = w_top_dec;
      end else begin
        w_udf_next = 1'b1;
      end
    end else if (PR_Call) begin
      w_push     = 1'b1;
      w_pc_next  = w_target;
      w_top_next = w_top_inc;
      // When full, the slot after top holds the oldest entry and is overwritten.
      if (r_count == DEPTH_C) begin
        w_ovf_next = 1'b1;
      end else begin
        w_count_next = r_count + CW'(1);
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (PR_Write_PC[i]) begin
          w_pc_next[8*i +: 8] = w_target[8*i +: 8];
        end else if (PR_Inc_PC) begin
          w_pc_next[8*i +: 8] = w_pc_inc[8*i +: 8];
        end else begin
          w_pc_next[8*i +: 8] = r_pc[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc     <= RESET_PC;
      r_not_pc <= ~RESET_PC;
      r_count  <= '0;
      r_top    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_pc     <= w_pc_next;
      r_not_pc <= ~w_pc_next;
      r_count  <= w_count_next;
      r_top    <= w_top_next;
      r_ovf    <= w_ovf_next;
      r_udf    <= w_udf_next;
    end
  end

  // Storage is not reset; only the count decides which entries are valid.
  always_ff @(posedge Clk) begin
    if (!Rst && w_push) begin
      r_stack[w_top_inc] <= w_pc_inc;
    end
  end

  assign PC             = r_pc;
  assign notPC          = r_not_pc;
  assign StackDepth     = r_count;
  assign StackEmpty     = (r_count == '0);
  assign StackFull      = (r_count == DEPTH_C);
  assign StackOverflow  = r_ovf;
  assign StackUnderflow = r_udf;

endmodule

// File: tb/tb_register_pc_stack.sv
// Directed bench for register_pc_stack (W=16, DEPTH=4, STEP=1, RESET_PC=0).
module tb_register_pc_stack;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] notALUResult = 16'hFFFF;
  logic [1:0]  PR_Write_PC = 2'b00;
  logic        PR_Inc_PC = 1'b0;
  logic        PR_Call = 1'b0;
  logic        PR_Ret = 1'b0;
  logic [15:0] PC;
  logic [15:0] notPC;
  logic [2:0]  StackDepth;
  logic        StackEmpty;
  logic        StackFull;
  logic        StackOverflow;
  logic        StackUnderflow;

  int n_checks = 0;
  int n_fail   = 0;

  register_pc_stack #(
    .W        (16),
    .DEPTH    (4),
    .STEP     (1),
    .RESET_PC (16'h0000)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .notALUResult   (notALUResult),
    .PR_Write_PC    (PR_Write_PC),
    .PR_Inc_PC      (PR_Inc_PC),
    .PR_Call        (PR_Call),
    .PR_Ret         (PR_Ret),
    .PC             (PC),
    .notPC          (notPC),
    .StackDepth     (StackDepth),
    .StackEmpty     (StackEmpty),
    .StackFull      (StackFull),
    .StackOverflow  (StackOverflow),
    .StackUnderflow (StackUnderflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; controls are single-cycle pulses, sampling is 1 time unit after.
  task automatic step();
    @(posedge Clk);
    #1;
    Rst         = 1'b0;
    PR_Write_PC = 2'b00;
    PR_Inc_PC   = 1'b0;
    PR_Call     = 1'b0;
    PR_Ret      = 1'b0;
  endtask

  task automatic load(input logic [15:0] val);
    PR_Write_PC  = 2'b11;
    notALUResult = ~val;
    step();
  endtask

  task automatic call(input logic [15:0] target);
    PR_Call      = 1'b1;
    notALUResult = ~target;
    step();
  endtask

  task automatic ret();
    PR_Ret = 1'b1;
    step();
  endtask

  initial begin
    // 1. Reset state
    #1;
    Rst = 1'b1;
    step();
    check("rst_pc", 32'(PC), 32'h0000);
    check("rst_npc", 32'(notPC), 32'hFFFF);
    check("rst_depth", 32'(StackDepth), 32'd0);
    check("rst_empty", 32'(StackEmpty), 32'd1);
    check("rst_full", 32'(StackFull), 32'd0);
    check("rst_ovf", 32'(StackOverflow), 32'd0);
    check("rst_udf", 32'(StackUnderflow), 32'd0);

    // 2. Increment with wrap
    load(16'hFFFE);
    check("load_fffe", 32'(PC), 32'hFFFE);
    PR_Inc_PC = 1'b1; step();
    check("inc_ffff", 32'(PC), 32'hFFFF);
    PR_Inc_PC = 1'b1; step();
    check("inc_wrap", 32'(PC), 32'h0000);
    check("inc_wrap_npc", 32'(notPC), 32'hFFFF);
    PR_Inc_PC = 1'b1; step();
    check("inc_0001", 32'(PC), 32'h0001);
    check("inc_0001_npc", 32'(notPC), 32'hFFFE);
    step();
    check("hold", 32'(PC), 32'h0001);

    // 3. Per-lane writes
    load(16'h1234);
    PR_Write_PC = 2'b01; PR_Inc_PC = 1'b1; notALUResult = ~16'hABCD; step();
    check("lane0_inc", 32'(PC), 32'h12CD);
    PR_Write_PC = 2'b10; notALUResult = ~16'hABCD; step();
    check("lane1", 32'(PC), 32'hABCD);
    check("lane1_npc", 32'(notPC), 32'h5432);
    // Increment carry crosses the lane boundary.
    load(16'h00FF);
    PR_Inc_PC = 1'b1; step();
    check("lane_carry", 32'(PC), 32'h0100);

    // 4. Call / return
    call(16'h0800);
    check("call_pc", 32'(PC), 32'h0800);
    check("call_depth", 32'(StackDepth), 32'd1);
    check("call_empty", 32'(StackEmpty), 32'd0);
    ret();
    check("ret_pc", 32'(PC), 32'h0101);
    check("ret_empty", 32'(StackEmpty), 32'd1);
    check("ret_depth", 32'(StackDepth), 32'd0);

    // 5. Overflow and underflow
    load(16'h0010); call(16'h1000);
    load(16'h0020); call(16'h1000);
    load(16'h0030); call(16'h1000);
    load(16'h0040); call(16'h1000);
    check("full4_full", 32'(StackFull), 32'd1);
    check("full4_ovf", 32'(StackOverflow), 32'd0);
    load(16'h0050); call(16'h1000);
    check("ovf_flag", 32'(StackOverflow), 32'd1);
    check("ovf_depth", 32'(StackDepth), 32'd4);
    check("ovf_pc", 32'(PC), 32'h1000);
    ret();
    check("pop1", 32'(PC), 32'h0051);
    ret();
    check("pop2", 32'(PC), 32'h0041);
    ret();
    check("pop3", 32'(PC), 32'h0031);
    ret();
    check("pop4", 32'(PC), 32'h0021);
    check("pop4_udf", 32'(StackUnderflow), 32'd0);
    ret();
    check("udf_pc", 32'(PC), 32'h0021);
    check("udf_flag", 32'(StackUnderflow), 32'd1);
    check("udf_depth", 32'(StackDepth), 32'd0);
    check("ovf_sticky", 32'(StackOverflow), 32'd1);
    PR_Inc_PC = 1'b1; step();
    check("udf_sticky", 32'(StackUnderflow), 32'd1);

    // 6. Reset beats call; return beats call
    load(16'h0300); call(16'h0400); call(16'h0500);
    check("d2_depth", 32'(StackDepth), 32'd2);
    Rst = 1'b1; PR_Call = 1'b1; notALUResult = ~16'h0600; step();
    check("rstcall_pc", 32'(PC), 32'h0000);
    check("rstcall_depth", 32'(StackDepth), 32'd0);
    check("rstcall_ovf", 32'(StackOverflow), 32'd0);
    check("rstcall_udf", 32'(StackUnderflow), 32'd0);
    load(16'h0200); call(16'h0300);
    check("d1_depth", 32'(StackDepth), 32'd1);
    PR_Call = 1'b1; PR_Ret = 1'b1; notALUResult = ~16'h0700; step();
    check("callret_pc", 32'(PC), 32'h0201);
    check("callret_depth", 32'(StackDepth), 32'd0);
    check("callret_ovf", 32'(StackOverflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
